change_monitor: RTL and testbench

Hardware counterpart of a `$monitor` statement. It samples a watched data bus and integer bus on every clock and keeps a free-running timestamp counter. Whenever either watched value differs from its last logged value, it pushes a {timestamp, data, ival} record into a small FIFO. It sits directly downstream of the register/stimulus stage that updates `data` and `i_value`, and presents records on a valid/ready stream for a trace sink or UART logger.

---
 rtl/change_monitor.sv | 94 +++++++++
 tb/tb_change_monitor.sv | 130 +++++++++++++
 2 files changed

// File: rtl/change_monitor.sv
// change_monitor: logs {timestamp, data, ival} into a FWFT FIFO whenever a watched value changes.
// Define CHG_MON_DELTA_TS_EN to stamp records with cycles since the previous log instead of absolute time.
module change_monitor #(
  parameter int DATA_W = 4,
  parameter int IVAL_W = 8,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [IVAL_W-1:0] ival_in,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [TS_W-1:0]   rec_ts,
  output logic [DATA_W-1:0] rec_data,
  output logic [IVAL_W-1:0] rec_ival,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_W + DATA_W + IVAL_W;
  logic [TS_W-1:0]   ts_q, ts_d, stamp;
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;
  logic [IVAL_W-1:0] last_ival_q, last_ival_d;
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [RW-1:0]     mem_q [DEPTH];
  logic              chg, push, pop, drop, empty, full;
`ifdef CHG_MON_DELTA_TS_EN
  logic [TS_W-1:0]   delta_q, delta_d, delta_inc;
`endif
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    chg = en && (!armed_q || data_in != last_data_q || ival_in != last_ival_q);
    pop = !empty && rec_ready;
    push = chg && (!full || pop);
    drop = chg && full && !pop;
    ts_d = ts_q + 1'b1;
    armed_d = en;
    last_data_d = chg ? data_in : last_data_q;
    last_ival_d = chg ? ival_in : last_ival_q;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    ovf_d = ovf_q | drop;
    drop_cnt_d = (drop && drop_cnt_q != 8'hff) ? drop_cnt_q + 8'd1 : drop_cnt_q;
`ifdef CHG_MON_DELTA_TS_EN
    delta_inc = &delta_q ? delta_q : delta_q + 1'b1;
    stamp = armed_q ? delta_inc : '0;
    delta_d = chg ? '0 : delta_inc;
`else
    stamp = ts_q;
`endif
    rec_valid = !empty;
    {rec_ts, rec_data, rec_ival} = empty ? '0 : mem_q[rd_q[AW-1:0]];
    overflow = ovf_q;
    drop_cnt = drop_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q <= '0;
      armed_q <= 1'b0;
      last_data_q <= '0;
      last_ival_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q <= ts_d;
      armed_q <= armed_d;
      last_data_q <= last_data_d;
      last_ival_q <= last_ival_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`ifdef CHG_MON_DELTA_TS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) delta_q <= '0;
    else delta_q <= delta_d;
  end
`endif
  // storage needs no reset: the pointers alone define which entries are live
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {stamp, data_in, ival_in};
  end
endmodule

// File: tb/tb_change_monitor.sv
// tb_change_monitor: directed self-checking bench for change_monitor (default absolute-timestamp build).
module tb_change_monitor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] data_in = '0;
  logic [7:0] ival_in = '0;
  logic       rec_valid, rec_ready = 1'b0, overflow;
  logic [15:0] rec_ts;
  logic [3:0] rec_data;
  logic [7:0] rec_ival, drop_cnt;
  int checks = 0, passed = 0, fails = 0;

  change_monitor #(.DATA_W(4), .IVAL_W(8), .TS_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .ival_in(ival_in),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ts(rec_ts),
    .rec_data(rec_data), .rec_ival(rec_ival), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic [15:0] ts, input logic [3:0] d, input logic [7:0] iv);
    chk({tag, ".valid"}, {31'd0, rec_valid}, 32'd1);
    chk({tag, ".rec"}, {rec_ts, rec_data, 4'd0, rec_ival}, {ts, d, 4'd0, iv});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_valid", {31'd0, rec_valid}, 32'd0);
    chk("rst_rec", {rec_ts, rec_data, 4'd0, rec_ival}, 32'd0);
    chk("rst_ovf", {23'd0, overflow, drop_cnt}, 32'd0);
    // single initial record, values held afterwards
    en = 1'b1; data_in = 4'd4; ival_in = 8'd4;
    do_reset();
    tick();
    chk_rec("first", 16'd0, 4'd4, 8'd4);
    tick();
    chk_rec("first_hold", 16'd0, 4'd4, 8'd4);
    rec_ready = 1'b1;
    tick();
    chk("first_only", {31'd0, rec_valid}, 32'd0);
    // change stream with always-ready sink; absolute ts after fresh reset
    #3; do_reset();
    tick();
    chk_rec("s0", 16'd0, 4'd4, 8'd4);
    tick();
    chk("s1_empty", {31'd0, rec_valid}, 32'd0);
    data_in = 4'd5;
    tick();
    chk_rec("s2", 16'd2, 4'd5, 8'd4);
    tick();
    tick();
    chk("s4_empty", {31'd0, rec_valid}, 32'd0);
    ival_in = 8'd10;
    tick();
    chk_rec("s5", 16'd5, 4'd5, 8'd10);
    ival_in = 8'd6;
    tick();
    chk_rec("s6", 16'd6, 4'd5, 8'd6);
    tick();
    chk("s7_empty", {31'd0, rec_valid}, 32'd0);
    chk("s_nodrop", {23'd0, overflow, drop_cnt}, 32'd0);
    // overflow: six changes with a stalled sink
    rec_ready = 1'b0; data_in = 4'd1; ival_in = 8'd0;
    #3; do_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      data_in = data_in + 4'd1;
    end
    chk("ovf_flags", {23'd0, overflow, drop_cnt}, {23'd0, 1'b1, 8'd2});
    chk_rec("ovf_head", 16'd0, 4'd1, 8'd0);
    // full + change + pop in same cycle: accepted, no drop (data_in is 7 now)
    rec_ready = 1'b1;
    tick();
    chk("fullpop_drop", {23'd0, overflow, drop_cnt}, {23'd0, 1'b1, 8'd2});
    chk_rec("fp1", 16'd1, 4'd2, 8'd0);
    tick();
    chk_rec("fp2", 16'd2, 4'd3, 8'd0);
    tick();
    chk_rec("fp3", 16'd3, 4'd4, 8'd0);
    tick();
    chk_rec("fp4", 16'd6, 4'd7, 8'd0);
    tick();
    chk("fp_empty", {31'd0, rec_valid}, 32'd0);
    // en 1->0->1 with unchanged values re-logs (ts now 11)
    en = 1'b0;
    tick();
    chk("en_off", {31'd0, rec_valid}, 32'd0);
    en = 1'b1; rec_ready = 1'b0;
    tick();
    chk_rec("rearm", 16'd12, 4'd7, 8'd0);
    chk("ovf_sticky", {23'd0, overflow, drop_cnt}, {23'd0, 1'b1, 8'd2});
    // async reset while three records queued
    data_in = 4'd8;
    tick();
    data_in = 4'd9;
    tick();
    chk_rec("q3_head", 16'd12, 4'd7, 8'd0);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, rec_valid}, 32'd0);
    chk("arst_ovf", {23'd0, overflow, drop_cnt}, 32'd0);
    data_in = 4'd11;
    rst = 1'b0;
    tick();
    chk_rec("post_rst", 16'd0, 4'd11, 8'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
